// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) round-robin arbiter onto a single shared memory port.
// Each grant latches the request; the owner sees a one-cycle resp pulse when memory completes.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_read,
    input  logic        imem_write,
    input  logic [31:0] imem_address,
    input  logic [3:0]  imem_byte_enable,
    input  logic [31:0] imem_wdata,
    output logic        imem_resp,
    output logic [31:0] imem_rdata,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [31:0] dmem_address,
    input  logic [3:0]  dmem_byte_enable,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_resp,
    output logic [31:0] dmem_rdata,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [3:0]  pmem_byte_enable,
    output logic [31:0] pmem_wdata,
    input  logic        pmem_resp,
    input  logic [31:0] pmem_rdata
);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StDone} state_e;

    state_e      state_q, state_d;
    logic        last_d_q, last_d_d;      // 1 when the data port won the last grant
    logic        abandon_q, abandon_d;    // owner dropped its request during the transaction
    logic        pmem_read_q, pmem_read_d;
    logic        pmem_write_q, pmem_write_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        imem_resp_q, imem_resp_d;
    logic        dmem_resp_q, dmem_resp_d;
    logic [31:0] imem_rdata_q, imem_rdata_d;
    logic [31:0] dmem_rdata_q, dmem_rdata_d;

    logic i_req, d_req, pick_d, own_req, wr;

    assign i_req = imem_read | imem_write;
    assign d_req = dmem_read | dmem_write;

    always_comb begin
        state_d      = state_q;
        last_d_d     = last_d_q;
        abandon_d    = abandon_q;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        imem_resp_d  = 1'b0;
        dmem_resp_d  = 1'b0;
        imem_rdata_d = imem_rdata_q;
        dmem_rdata_d = dmem_rdata_q;
        pick_d       = d_req && (!i_req || !last_d_q);
        own_req      = (state_q == StBusyD) ? d_req : i_req;
        wr           = pick_d ? dmem_write : imem_write;

        unique case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    last_d_d     = pick_d;
                    abandon_d    = 1'b0;
                    addr_d       = pick_d ? dmem_address : imem_address;
                    be_d         = pick_d ? dmem_byte_enable : imem_byte_enable;
                    wdata_d      = pick_d ? dmem_wdata : imem_wdata;
                    // Write wins when a port raises both read and write.
                    pmem_write_d = wr;
                    pmem_read_d  = !wr;
                    state_d      = pick_d ? StBusyD : StBusyI;
                end
            end
            StBusyI, StBusyD: begin
                if (!own_req) abandon_d = 1'b1;
                if (pmem_resp) begin
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    if (state_q == StBusyD) begin
                        dmem_rdata_d = pmem_rdata;
                        dmem_resp_d  = own_req && !abandon_q;
                    end else begin
                        imem_rdata_d = pmem_rdata;
                        imem_resp_d  = own_req && !abandon_q;
                    end
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_d_q     <= 1'b0;
            abandon_q    <= 1'b0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            imem_resp_q  <= 1'b0;
            dmem_resp_q  <= 1'b0;
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_d_q     <= last_d_d;
            abandon_q    <= abandon_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            imem_resp_q  <= imem_resp_d;
            dmem_resp_q  <= dmem_resp_d;
            imem_rdata_q <= imem_rdata_d;
            dmem_rdata_q <= dmem_rdata_d;
        end
    end

    assign pmem_read        = pmem_read_q;
    assign pmem_write       = pmem_write_q;
    assign pmem_address     = addr_q;
    assign pmem_byte_enable = be_q;
    assign pmem_wdata       = wdata_q;
    assign imem_resp        = imem_resp_q;
    assign dmem_resp        = dmem_resp_q;
    assign imem_rdata       = imem_rdata_q;
    assign dmem_rdata       = dmem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: hand-computed expectations checked with immediate assertions.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_read = 1'b0, imem_write = 1'b0;
    logic [31:0] imem_address = '0, imem_wdata = '0;
    logic [3:0]  imem_byte_enable = '0;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        dmem_read = 1'b0, dmem_write = 1'b0;
    logic [31:0] dmem_address = '0, dmem_wdata = '0;
    logic [3:0]  dmem_byte_enable = '0;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        pmem_read, pmem_write;
    logic [31:0] pmem_address, pmem_wdata;
    logic [3:0]  pmem_byte_enable;
    logic        pmem_resp = 1'b0;
    logic [31:0] pmem_rdata = '0;

    int total = 0;
    int bad   = 0;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .imem_read(imem_read), .imem_write(imem_write), .imem_address(imem_address),
        .imem_byte_enable(imem_byte_enable), .imem_wdata(imem_wdata),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
        .dmem_byte_enable(dmem_byte_enable), .dmem_wdata(dmem_wdata),
        .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_byte_enable(pmem_byte_enable), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_pmem_read", 32'(pmem_read), 32'd0);
        chk("rst_pmem_write", 32'(pmem_write), 32'd0);
        chk("rst_pmem_addr", pmem_address, 32'd0);
        chk("rst_imem_resp", 32'(imem_resp), 32'd0);
        chk("rst_dmem_rdata", dmem_rdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // I-read alone, memory answers in the third busy cycle
        imem_read = 1'b1; imem_address = 32'h60;
        tick();
        chk("i1_cmd_c1", 32'(pmem_read), 32'd1);
        chk("i1_addr_c1", pmem_address, 32'h60);
        chk("i1_nowrite", 32'(pmem_write), 32'd0);
        tick();
        chk("i1_cmd_c2", 32'(pmem_read), 32'd1);
        tick();
        chk("i1_cmd_c3", 32'(pmem_read), 32'd1);
        chk("i1_noresp_busy", 32'(imem_resp), 32'd0);
        pmem_resp = 1'b1; pmem_rdata = 32'h00A00093;
        tick();
        pmem_resp = 1'b0; imem_read = 1'b0;
        chk("i1_cmd_off", 32'(pmem_read), 32'd0);
        chk("i1_resp", 32'(imem_resp), 32'd1);
        chk("i1_rdata", imem_rdata, 32'h00A00093);
        chk("i1_dmem_resp", 32'(dmem_resp), 32'd0);
        tick();
        chk("i1_resp_once", 32'(imem_resp), 32'd0);

        // Fresh reset so last-grant is I: simultaneous pair goes to D first
        rst_n = 1'b0; #1; rst_n = 1'b1;
        imem_read = 1'b1; imem_address = 32'h100;
        dmem_write = 1'b1; dmem_address = 32'h2000; dmem_wdata = 32'hDEADBEEF;
        dmem_byte_enable = 4'hF;
        tick();
        chk("rr1_write", 32'(pmem_write), 32'd1);
        chk("rr1_read", 32'(pmem_read), 32'd0);
        chk("rr1_addr", pmem_address, 32'h2000);
        chk("rr1_wdata", pmem_wdata, 32'hDEADBEEF);
        chk("rr1_be", 32'(pmem_byte_enable), 32'hF);
        dmem_address = 32'h3000;
        tick();
        chk("churn_addr", pmem_address, 32'h2000);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("rr1_dresp", 32'(dmem_resp), 32'd1);
        chk("rr1_iresp", 32'(imem_resp), 32'd0);
        // D re-requests alongside the still-pending I: I should now win
        dmem_write = 1'b0; dmem_read = 1'b1; dmem_address = 32'h4000;
        tick();
        chk("rr_idle_gap", 32'(pmem_read), 32'd0);
        tick();
        chk("rr2_iread", 32'(pmem_read), 32'd1);
        chk("rr2_addr", pmem_address, 32'h100);
        pmem_resp = 1'b1; pmem_rdata = 32'h11111111;
        tick();
        pmem_resp = 1'b0; imem_read = 1'b0;
        chk("rr2_iresp", 32'(imem_resp), 32'd1);
        chk("rr2_irdata", imem_rdata, 32'h11111111);
        chk("rr2_dresp", 32'(dmem_resp), 32'd0);
        tick();
        tick();
        chk("rr3_addr", pmem_address, 32'h4000);
        chk("rr3_read", 32'(pmem_read), 32'd1);
        pmem_resp = 1'b1; pmem_rdata = 32'h22222222;
        tick();
        pmem_resp = 1'b0; dmem_read = 1'b0;
        chk("rr3_dresp", 32'(dmem_resp), 32'd1);
        chk("rr3_drdata", dmem_rdata, 32'h22222222);
        chk("rr3_irdata_hold", imem_rdata, 32'h11111111);
        tick();

        // Abandonment: I drops mid-transaction, D waits and is granted afterwards
        imem_read = 1'b1; imem_address = 32'h200;
        tick();
        chk("ab_cmd", 32'(pmem_read), 32'd1);
        imem_read = 1'b0; dmem_read = 1'b1; dmem_address = 32'h500;
        tick();
        chk("ab_held", 32'(pmem_read), 32'd1);
        chk("ab_addr", pmem_address, 32'h200);
        pmem_resp = 1'b1; pmem_rdata = 32'h33333333;
        tick();
        pmem_resp = 1'b0;
        chk("ab_no_iresp", 32'(imem_resp), 32'd0);
        chk("ab_no_dresp", 32'(dmem_resp), 32'd0);
        tick();
        tick();
        chk("ab_dgrant", pmem_address, 32'h500);
        chk("ab_dread", 32'(pmem_read), 32'd1);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; dmem_read = 1'b0;
        chk("ab_dresp", 32'(dmem_resp), 32'd1);
        tick();

        // Byte-lane write
        dmem_write = 1'b1; dmem_byte_enable = 4'h4; dmem_wdata = 32'h00AB0000;
        dmem_address = 32'h10;
        tick();
        chk("bw_be", 32'(pmem_byte_enable), 32'h4);
        chk("bw_wdata", pmem_wdata, 32'h00AB0000);
        chk("bw_write", 32'(pmem_write), 32'd1);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; dmem_write = 1'b0;
        chk("bw_resp", 32'(dmem_resp), 32'd1);
        tick();
        chk("bw_resp_once", 32'(dmem_resp), 32'd0);

        // Read and write together: write wins
        imem_read = 1'b1; imem_write = 1'b1; imem_address = 32'h30;
        tick();
        chk("rw_write", 32'(pmem_write), 32'd1);
        chk("rw_noread", 32'(pmem_read), 32'd0);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; imem_read = 1'b0; imem_write = 1'b0;
        chk("rw_resp", 32'(imem_resp), 32'd1);
        tick();

        // Reset in the middle of a D transaction
        dmem_read = 1'b1; dmem_address = 32'h700;
        tick();
        chk("mr_cmd", 32'(pmem_read), 32'd1);
        rst_n = 1'b0; dmem_read = 1'b0;
        #1;
        chk("mr_read0", 32'(pmem_read), 32'd0);
        chk("mr_addr0", pmem_address, 32'd0);
        chk("mr_irdata0", imem_rdata, 32'd0);
        chk("mr_drdata0", dmem_rdata, 32'd0);
        rst_n = 1'b1;
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("mr_late_dresp", 32'(dmem_resp), 32'd0);
        chk("mr_idle_read", 32'(pmem_read), 32'd0);
        tick();
        chk("mr_late_dresp2", 32'(dmem_resp), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
